assoc_dcache: RTL
=================

# assoc_dcache

Two-way set-associative, write-back, write-allocate data cache placed between the CPU load/store port and the block-oriented data memory. It replaces the direct-mapped data cache, using the same CPU-side read/write/busywait handshake and the same memory-side block handshake. Geometry is parametrised, and replacement uses one LRU bit per set.

## Interface
- ADDR_W, 8, CPU byte-address width
- WORD_W, 8, CPU data word width
- BLOCK_WORDS, 4, words per block (power of 2); OFF_W = log2(BLOCK_WORDS)
- SETS, 4, sets (power of 2); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears state immediately on assertion
- read  in  1  CPU load request, held until busywait is sampled low
- write  in  1  CPU store request, held until busywait is sampled low
- address  in  ADDR_W  {tag, index, offset}
- writedata  in  WORD_W  store data
- readdata  out  WORD_W  load data
- busywait  out  1  CPU stall
- mem_read  out  1  block fetch request
- mem_write  out  1  block write-back request
- mem_address  out  ADDR_W-OFF_W  block address {tag, index}
- mem_writedata  out  WORD_W*BLOCK_WORDS  write-back block; word 0 in the LSBs
- mem_readdata  in  WORD_W*BLOCK_WORDS  fetched block
- mem_busywait  in  1  memory stall

## Operation
- Per way and set: valid, dirty, tag, and data block. Per set: lru, which points at the least-recently-used way.
- hit_w = valid[w][idx] && tag[w][idx]==tag. hit = hit_0 | hit_1. At most one way can hit.
- read and write both high is treated as write.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE:
  - Request with hit: completes this cycle.
  - Request with miss: select a victim. The victim is way 0 if it is invalid, else way 1 if it is invalid, else way lru[idx]. Go to WRITEBACK if the victim is dirty, otherwise go to FETCH. The victim way is latched.
- WRITEBACK: mem_write=1, mem_address={victim tag, idx}, mem_writedata=victim block. Stay while mem_busywait=1. On the posedge with mem_busywait=0, clear the victim's dirty bit and go to FETCH.
- FETCH: mem_read=1, mem_address={tag, idx}. Stay while mem_busywait=1. On the posedge with mem_busywait=0:
  - Write mem_readdata into the victim way.
  - Set the victim's tag, valid=1, dirty=0.
  - Go to IDLE. The retried access then hits.
- Read hit: readdata = word[offset] of the hitting way, driven combinationally. readdata=0 whenever there is no read hit.
- Write hit: at the posedge, write writedata into word[offset] of the hitting way and set dirty=1.
- LRU update: on every hit-completing posedge, lru[idx] = the other way. Fills do not change lru; the access that follows does.
- Outside WRITEBACK/FETCH: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
- Reset (while reset=0):
  - All valid, dirty and lru bits are cleared.
  - State goes to IDLE.
  - Memory outputs go to 0 immediately, even mid-transfer. The aborted transfer is discarded.
  - Data and tag arrays need not be cleared.

## Timing
- busywait = (read|write) && !(state==IDLE && hit), purely combinational, with no extra posedge of wait on a hit. busywait is 0 with no request and during reset.
- Hit latency: 0 wait cycles. The CPU samples busywait=0 at the posedge at which a store commits.
- Clean miss: 1 cycle in IDLE detecting the miss, then FETCH for Lm+1 cycles, where Lm is the number of cycles with mem_busywait=1. The hit then completes in the next IDLE cycle.
- Dirty miss: the clean-miss latency plus Lw+1 cycles of WRITEBACK.
- mem_read and mem_write are never high together. They are held stable, together with mem_address and mem_writedata, for the whole of each transfer.
- Request, address or data changing while busywait=1 is a CPU protocol violation, and behaviour is undefined.

## Test plan
- Cold read: after reset, read address 0x00; the memory returns 0x44332211 after 2 wait cycles. Required:
  - busywait=1 and mem_read=1 with mem_address=0x00.
  - Exactly one further cycle with read=1 and busywait=0, showing readdata=0x11.
  - Then a read of 0x03 returns 0x44 with busywait=0 in the same cycle.
- Write hit then eviction on set 0 (continuing):
  - Write 0xAA to 0x00: 0 wait cycles.
  - Read 0x10: fills way 1.
  - Read 0x20: WRITEBACK with mem_address=0x00 and mem_writedata=0x443322AA, followed by FETCH with mem_address=0x08.
- LRU: after 0x00/0x10 fill set 0, read 0x00 and then miss on 0x20. The victim must be way 1, so 0x10 is evicted, and the following read of 0x00 hits with 0 wait cycles.
- Clean eviction: the victim's dirty bit is 0. The FSM goes IDLE→FETCH directly, and mem_write is never asserted.
- Reset mid-FETCH: pull reset low while mem_read=1. Required:
  - mem_read drops immediately.
  - After release, a read of the same address misses again, because valid is cleared.
- Simultaneous read+write hit on 0x01 with writedata 0x5C: treated as a write. A later read of 0x01 returns 0x5C, and readdata is 0 during the write cycle.

Source files
------------

// File: rtl/assoc_dcache.sv
// assoc_dcache: two-way set-associative write-back/write-allocate data cache with per-set LRU bit
module assoc_dcache #(
   parameter int ADDR_W      = 8,
   parameter int WORD_W      = 8,
   parameter int BLOCK_WORDS = 4,
   parameter int SETS        = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          read,
   input  logic                          write,
   input  logic [ADDR_W-1:0]             address,
   input  logic [WORD_W-1:0]             writedata,
   output logic [WORD_W-1:0]             readdata,
   output logic                          busywait,
   output logic                          mem_read,
   output logic                          mem_write,
   output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0] mem_address,
   output logic [WORD_W*BLOCK_WORDS-1:0] mem_writedata,
   input  logic [WORD_W*BLOCK_WORDS-1:0] mem_readdata,
   input  logic                          mem_busywait
);
   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int BLK_W = WORD_W * BLOCK_WORDS;
   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
   state_t state, state_d;
   logic [1:0][SETS-1:0] valid, dirty;
   logic [SETS-1:0] lru;
   logic [TAG_W-1:0] tag_q [2][SETS];
   logic [BLK_W-1:0] data_q [2][SETS];
   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic [BLK_W-1:0] hit_blk;
   logic req, hit0, hit1, hit, hit_way, vsel, victim, done_hit, fill;
   assign tag      = address[ADDR_W-1 -: TAG_W];
   assign idx      = address[OFF_W +: IDX_W];
   assign off      = address[OFF_W-1:0];
   assign req      = read | write;
   assign hit0     = valid[0][idx] && tag_q[0][idx] == tag;
   assign hit1     = valid[1][idx] && tag_q[1][idx] == tag;
   assign hit      = hit0 | hit1;
   assign hit_way  = hit1;
   assign hit_blk  = data_q[hit_way][idx];
   assign done_hit = req && state == IDLE && hit;
   assign fill     = state == FETCH && !mem_busywait;
   assign readdata = (done_hit && !write) ? hit_blk[off*WORD_W +: WORD_W] : '0;
   assign busywait = reset && req && !(state == IDLE && hit);
   // invalid ways are preferred over the LRU way so cold sets fill without eviction
   assign vsel     = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
   always_comb begin
      state_d       = state;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      case (state)
         IDLE: if (req && !hit) state_d = dirty[vsel][idx] ? WRITEBACK : FETCH;
         WRITEBACK: begin
            mem_write     = 1'b1;
            mem_address   = {tag_q[victim][idx], idx};
            mem_writedata = data_q[victim][idx];
            if (!mem_busywait) state_d = FETCH;
         end
         FETCH: begin
            mem_read    = 1'b1;
            mem_address = {tag, idx};
            if (!mem_busywait) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         victim <= 1'b0;
         valid  <= '0;
         dirty  <= '0;
         lru    <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && req && !hit) victim <= vsel;
         if (done_hit) begin
            lru[idx] <= ~hit_way;
            if (write) dirty[hit_way][idx] <= 1'b1;
         end
         if (state == WRITEBACK && !mem_busywait) dirty[victim][idx] <= 1'b0;
         if (fill) begin
            valid[victim][idx] <= 1'b1;
            dirty[victim][idx] <= 1'b0;
         end
      end
   end
   // tag and data arrays carry no reset; valid bits guard their contents
   always_ff @(posedge clock) begin
      if (done_hit && write) data_q[hit_way][idx][off*WORD_W +: WORD_W] <= writedata;
      if (fill) begin
         data_q[victim][idx] <= mem_readdata;
         tag_q[victim][idx]  <= tag;
      end
   end
endmodule
